// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe
//   Decodes a RISC-V style immediate from an instruction word and queues the
//   extended result in a 2-entry FIFO skid buffer.
//
//   Handshake (both sides): a transfer happens on a rising clk edge where
//   valid and ready are both high. Nothing is sampled on any other edge.
//   in_ready depends only on registered state and rst, never on in_valid.
//   Once out_valid rises, imm/imm_err hold until the consumer takes them.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset
//   flush      in   synchronous flush, drops all entries and any same-cycle push
//   in_valid   in   request valid
//   in_ready   out  request accepted when high together with in_valid
//   inst       in   instruction word
//   imm_type   in   immediate format select (7 = illegal)
//   out_valid  out  result valid
//   out_ready  in   consumer accepts result
//   imm        out  extended immediate (oldest entry)
//   imm_err    out  illegal imm_type flag, travels with imm
//   dbg_state  out  buffer state: 0 EMPTY, 1 ONE, 2 TWO

module imm_gen_pipe #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [INST_WIDTH-1:0]           inst,
    input  logic [$clog2(IMM_TYPE_NUM)-1:0] imm_type,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_WIDTH-1:0]           imm,
    output logic                            imm_err,
    output logic [1:0]                      dbg_state
);

    localparam int TYPE_W  = $clog2(IMM_TYPE_NUM);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_e;

    state_e                  state_q;
    logic [DATA_WIDTH-1:0]   head_imm_q;
    logic                    head_err_q;
    logic [DATA_WIDTH-1:0]   tail_imm_q;
    logic                    tail_err_q;

    logic [DATA_WIDTH-1:0]   imm_d;
    logic                    imm_err_d;
    logic [63:0]             wide;
    logic                    push;
    logic                    pop;

    // Bits [6:0] carry the opcode and never feed an immediate.
    logic unused_opcode;
    assign unused_opcode = ^inst[6:0];

    // Every format is built at 64 bits and then cut to DATA_WIDTH, so a
    // 32-bit build only loses the sign copies above bit 31 (U and J).
    always_comb begin
        wide      = '0;
        imm_err_d = 1'b0;
        case (imm_type)
            TYPE_W'(0): wide = {{52{inst[31]}}, inst[31:20]};
            TYPE_W'(1): wide[SHAMT_W-1:0] = inst[20 +: SHAMT_W];
            TYPE_W'(2): wide = {{52{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_W'(3): wide = {{51{inst[31]}}, inst[31], inst[7], inst[30:25],
                                inst[11:8], 1'b0};
            TYPE_W'(4): wide = {{32{inst[31]}}, inst[31:12], 12'b0};
            TYPE_W'(5): wide = {{43{inst[31]}}, inst[31], inst[19:12], inst[20],
                                inst[30:21], 1'b0};
            TYPE_W'(6): wide = {59'b0, inst[19:15]};
            default:    imm_err_d = 1'b1;
        endcase
    end

    assign imm_d = wide[DATA_WIDTH-1:0];

    assign in_ready  = !rst && (state_q != S_TWO);
    assign out_valid = (state_q != S_EMPTY);
    assign imm       = head_imm_q;
    assign imm_err   = head_err_q;
    assign dbg_state = state_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Priority: rst, then flush, then the push/pop transitions.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_EMPTY;
            head_imm_q <= '0;
            head_err_q <= 1'b0;
            tail_imm_q <= '0;
            tail_err_q <= 1'b0;
        end else if (flush) begin
            state_q <= S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: begin
                    if (push) begin
                        head_imm_q <= imm_d;
                        head_err_q <= imm_err_d;
                        state_q    <= S_ONE;
                    end
                end
                S_ONE: begin
                    case ({push, pop})
                        2'b10: begin
                            tail_imm_q <= imm_d;
                            tail_err_q <= imm_err_d;
                            state_q    <= S_TWO;
                        end
                        2'b01: begin
                            state_q <= S_EMPTY;
                        end
                        2'b11: begin
                            // Old head leaves, the new entry takes its place.
                            head_imm_q <= imm_d;
                            head_err_q <= imm_err_d;
                        end
                        default: ;
                    endcase
                end
                S_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        head_imm_q <= tail_imm_q;
                        head_err_q <= tail_err_q;
                        state_q    <= S_ONE;
                    end
                end
                default: begin
                    state_q <= S_EMPTY;
                end
            endcase
        end
    end

endmodule
